// File: rtl/block_fir_param.sv
// Parametrised block FIR: LANES samples per clock, TAPS-tap filter, 3-stage pipeline, loadable coefficients.
// Optional build macro BLOCK_FIR_SAT_EN clamps outputs to DATA_W; otherwise the result wraps.

module block_fir_lane #(
  parameter int TAPS      = 8,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    en,
  input  logic [TAPS-1:0][DATA_W-1:0]   win,
  input  logic [TAPS-1:0][COEF_W-1:0]   coef,
  output logic [DATA_W-1:0]             y
);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'((1 << OUT_SHIFT) >> 1);

  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [ACC_W-1:0]  sum, acc_q, rnd;
  logic        [DATA_W-1:0] yd;

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++)
      sum = sum + {{(ACC_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
  end

  // round half up, then arithmetic shift
  assign rnd = (acc_q + RND) >>> OUT_SHIFT;

`ifdef BLOCK_FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  always_comb begin
    if (rnd > MAXV)      yd = MAXV[DATA_W-1:0];
    else if (rnd < MINV) yd = MINV[DATA_W-1:0];
    else                 yd = rnd[DATA_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^rnd[ACC_W-1:DATA_W];
  assign yd = rnd[DATA_W-1:0];
`endif

  // each stage only moves on a valid slot, so out_data holds across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      acc_q <= '0;
      y     <= '0;
    end else begin
      if (en[0])
        for (int k = 0; k < TAPS; k++)
          prod_q[k] <= PROD_W'($signed(win[k])) * PROD_W'($signed(coef[k]));
      if (en[1]) acc_q <= sum;
      if (en[2]) y     <= yd;
    end
  end
endmodule

module block_fir_param #(
  parameter int LANES     = 5,
  parameter int TAPS      = 8,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_SHIFT = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_valid,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_wr_data,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_valid
);
  localparam int HW = TAPS - 1;

  logic [LANES-1:0][DATA_W-1:0]    lane_in;
  logic [HW-1:0][DATA_W-1:0]       hist_q;
  logic [HW+LANES-1:0][DATA_W-1:0] ext;
  logic [TAPS-1:0][COEF_W-1:0]     coef_q;
  logic [3:0]                      vld_pipe;

  assign lane_in = in_data;
  // ext[j]: oldest history at 0, lane l of the current block at HW+l
  assign ext = {lane_in, hist_q};
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[3:1] <= '0;
      hist_q        <= '0;
      coef_q        <= '0;
      coef_q[0]     <= COEF_W'(1 << OUT_SHIFT);
    end else begin
      vld_pipe[3:1] <= vld_pipe[2:0];
      if (in_valid) hist_q <= ext[HW+LANES-1:LANES];
      if (coef_wr_en && (int'(coef_addr) < TAPS)) coef_q[coef_addr] <= coef_wr_data;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [TAPS-1:0][DATA_W-1:0] win;
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign win[k] = ext[HW+l-k];
    end
    block_fir_lane #(
      .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_SHIFT(OUT_SHIFT)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (vld_pipe[2:0]),
      .win   (win),
      .coef  (coef_q),
      .y     (out_data[l*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_block_fir_param.sv
// Bench for block_fir_param: directed per-cycle table, then random traffic vs. a sample-stream model.
// A second instance with TAPS=6 exercises out-of-range coefficient addresses.

module tb_block_fir_param;
  localparam int L = 5, DW = 16, CW = 16, SH = 14;
  localparam int T0 = 8, T1 = 6;
  localparam int NCYC = 2048;

  typedef logic [L*DW-1:0] blk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid;
  blk_t          in_data;
  logic          cwe0, cwe1;
  logic [2:0]    ca0, ca1;
  logic [CW-1:0] cd0, cd1;
  blk_t          od0, od1;
  logic          ov0, ov1;

  block_fir_param #(.LANES(L), .TAPS(T0), .DATA_W(DW), .COEF_W(CW), .OUT_SHIFT(SH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .coef_wr_en(cwe0), .coef_addr(ca0), .coef_wr_data(cd0),
    .out_data(od0), .out_valid(ov0));

  block_fir_param #(.LANES(L), .TAPS(T1), .DATA_W(DW), .COEF_W(CW), .OUT_SHIFT(SH)) dut6 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .coef_wr_en(cwe1), .coef_addr(ca1), .coef_wr_data(cd1),
    .out_data(od1), .out_valid(ov1));

  int n_chk = 0, n_err = 0, cyc = 0;

  // reference model: whole accepted sample stream, coefficient images, output schedule by cycle
  longint stream[$];
  longint cm [2][8];
  bit     sv [NCYC];
  blk_t   sd0 [NCYC], sd1 [NCYC];
  blk_t   last0, last1;

  task automatic chk(input string nm, input blk_t act, input blk_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic blk_t calc(int inst, int base);
    blk_t r;
    longint acc, x;
    int taps;
    taps = (inst == 0) ? T0 : T1;
    r = '0;
    for (int l = 0; l < L; l++) begin
      acc = 0;
      for (int k = 0; k < taps; k++) begin
        int idx;
        idx = base + l - k;
        x = (idx >= 0) ? stream[idx] : 0;
        acc += cm[inst][k] * x;
      end
      acc = (acc + (64'sd1 <<< (SH-1))) >>> SH;
`ifdef BLOCK_FIR_SAT_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`endif
      r[l*DW +: DW] = acc[DW-1:0];
    end
    return r;
  endfunction

  task automatic step();
    bit rs;
    rs = reset;
    if (rs) begin
      stream.delete();
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 8; k++) cm[i][k] = (k == 0) ? (64'sd1 <<< SH) : 0;
      sv[cyc+1] = 0;
      sv[cyc+2] = 0;
    end else begin
      if (in_valid) begin
        int base;
        base = stream.size();
        for (int l = 0; l < L; l++) stream.push_back(longint'($signed(in_data[l*DW +: DW])));
        sv[cyc+2]  = 1;
        sd0[cyc+2] = calc(0, base);
        sd1[cyc+2] = calc(1, base);
      end
      if (cwe0 && int'(ca0) < T0) cm[0][ca0] = longint'($signed(cd0));
      if (cwe1 && int'(ca1) < T1) cm[1][ca1] = longint'($signed(cd1));
    end
    @(posedge clk); #1;
    if (rs) begin
      last0 = '0; last1 = '0;
    end else if (sv[cyc]) begin
      last0 = sd0[cyc]; last1 = sd1[cyc];
    end
    chk("valid8", blk_t'(ov0), blk_t'(!rs && sv[cyc]));
    chk("data8",  od0, last0);
    chk("valid6", blk_t'(ov1), blk_t'(!rs && sv[cyc]));
    chk("data6",  od1, last1);
    cyc++;
  endtask

  typedef struct {
    bit rst; bit vld; blk_t din;
    bit cwe; logic [2:0] ca; logic [CW-1:0] cd;
    bit cwe1; logic [2:0] ca1;
    bit ev; blk_t ed;
  } vec_t;

  function automatic blk_t blk(int a, int b, int c, int d, int e);
    return {DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction
  function automatic blk_t all(int v);
    return blk(v, v, v, v, v);
  endfunction
  function automatic vec_t row(bit rst, bit vld, blk_t din, bit cwe, int ca, int cd, bit ev, blk_t ed);
    vec_t r;
    r.rst = rst; r.vld = vld; r.din = din;
    r.cwe = cwe; r.ca = 3'(ca); r.cd = CW'(cd);
    r.cwe1 = 1'b0; r.ca1 = '0;
    r.ev = ev; r.ed = ed;
    return r;
  endfunction
  function automatic vec_t idle(bit ev, blk_t ed);
    return row(0, 0, '0, 0, 0, 0, ev, ed);
  endfunction

  vec_t tbl[$];

  initial begin
    blk_t id, i1, i2, i3, s, t;
    int sh, th;
`ifdef BLOCK_FIR_SAT_EN
    sh = 16'h7FFF; th = 16'h8000;
`else
    sh = 16'hFFFE; th = 16'h0000;
`endif
    id = blk(1, 2, 3, 4, 5);
    i1 = blk('h100, 'h80, 'h40, 0, 0);
    i2 = blk(0, 0, 0, 0, 'h100);
    i3 = blk('h80, 'h40, 0, 0, 0);
    s  = blk('h7FFF, sh, sh, sh, sh);
    t  = blk('hFFFF, th, th, th, th);

    // identity after reset
    tbl.push_back(row(1, 0, '0, 0, 0, 0, 0, '0));
    tbl.push_back(row(0, 1, id, 0, 0, 0, 0, '0));
    tbl.push_back(idle(0, '0));
    tbl.push_back(idle(1, id));
    tbl.push_back(idle(0, id));
    // impulse: c = {4000,2000,1000}; TAPS=6 instance gets writes at 6 and 7 that must be dropped
    tbl.push_back(row(1, 0, '0, 0, 0, 0, 0, '0));
    tbl.push_back(row(0, 0, '0, 1, 0, 'h4000, 0, '0));
    tbl[$].cwe1 = 1'b1; tbl[$].ca1 = 3'd6;
    tbl.push_back(row(0, 0, '0, 1, 1, 'h2000, 0, '0));
    tbl[$].cwe1 = 1'b1; tbl[$].ca1 = 3'd7;
    tbl.push_back(row(0, 0, '0, 1, 2, 'h1000, 0, '0));
    tbl.push_back(row(0, 1, blk('h100, 0, 0, 0, 0), 0, 0, 0, 0, '0));
    tbl.push_back(row(0, 1, i2, 0, 0, 0, 0, '0));
    tbl.push_back(row(0, 1, '0, 0, 0, 0, 1, i1));
    tbl.push_back(idle(1, i2));
    tbl.push_back(idle(1, i3));
    tbl.push_back(idle(0, i3));
    // same cross-block stream with a 1,0,0,1 valid pattern; bubble data must be ignored
    tbl.push_back(row(0, 1, i2, 0, 0, 0, 0, i3));
    tbl.push_back(row(0, 0, all('h7FFF), 0, 0, 0, 0, i3));
    tbl.push_back(row(0, 0, all('h7FFF), 0, 0, 0, 1, i2));
    tbl.push_back(row(0, 1, '0, 0, 0, 0, 0, i2));
    tbl.push_back(idle(0, i2));
    tbl.push_back(idle(1, i3));
    // saturation / wrap with c0 = c1 = 0x4000
    tbl.push_back(row(0, 0, '0, 1, 1, 'h4000, 0, i3));
    tbl.push_back(row(0, 0, '0, 1, 2, 0, 0, i3));
    tbl.push_back(row(0, 1, all('h7FFF), 0, 0, 0, 0, i3));
    tbl.push_back(row(0, 1, all('h7FFF), 0, 0, 0, 0, i3));
    tbl.push_back(row(0, 1, all('h8000), 0, 0, 0, 1, s));
    tbl.push_back(row(0, 1, all('h8000), 0, 0, 0, 1, all(sh)));
    tbl.push_back(idle(1, t));
    tbl.push_back(idle(1, all(th)));
    // coefficient write in the same cycle as block A
    tbl.push_back(row(1, 0, '0, 0, 0, 0, 0, '0));
    tbl.push_back(row(0, 1, all('h100), 1, 0, 'h2000, 0, '0));
    tbl.push_back(row(0, 1, all('h100), 0, 0, 0, 0, '0));
    tbl.push_back(idle(1, all('h100)));
    tbl.push_back(idle(1, all('h80)));
    // reset with three blocks in flight
    tbl.push_back(row(0, 1, all('h1234), 0, 0, 0, 0, all('h80)));
    tbl.push_back(row(0, 1, all('h5555), 0, 0, 0, 0, all('h80)));
    tbl.push_back(row(0, 1, all('h2222), 0, 0, 0, 1, all('h091A)));
    tbl.push_back(row(1, 1, all('h3333), 0, 0, 0, 0, '0));
    tbl.push_back(idle(0, '0));
    tbl.push_back(idle(0, '0));
    tbl.push_back(row(0, 1, id, 0, 0, 0, 0, '0));
    tbl.push_back(idle(0, '0));
    tbl.push_back(idle(1, id));
    tbl.push_back(idle(0, id));

    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    cwe0 = 1'b0; ca0 = '0; cd0 = '0;
    cwe1 = 1'b0; ca1 = '0; cd1 = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].din;
      cwe0 = tbl[i].cwe; ca0 = tbl[i].ca; cd0 = tbl[i].cd;
      cwe1 = tbl[i].cwe1; ca1 = tbl[i].ca1; cd1 = 16'h7FFF;
      step();
      chk("tbl_valid", blk_t'(ov0), blk_t'(tbl[i].ev));
      chk("tbl_data",  od0, tbl[i].ed);
    end

    // random traffic, coefficient writes and occasional resets
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      for (int l = 0; l < L; l++)
        in_data[l*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                          : DW'($urandom_range(0, 2047)) - 16'd1024;
      cwe0 = ($urandom_range(0, 5) == 0);
      ca0  = 3'($urandom_range(0, 7));
      cd0  = ($urandom_range(0, 1) == 0) ? CW'($urandom) : CW'($urandom_range(0, 8191)) - 16'd4096;
      cwe1 = ($urandom_range(0, 5) == 0);
      ca1  = 3'($urandom_range(0, 7));
      cd1  = ($urandom_range(0, 1) == 0) ? CW'($urandom) : CW'($urandom_range(0, 8191)) - 16'd4096;
      step();
    end

    reset = 1'b0; in_valid = 1'b0; cwe0 = 1'b0; cwe1 = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
